// File: rtl/mem_dma_initiator.sv
// Word-copy DMA initiator on the native valid/ready memory bus: reads LEN words from src and
// writes them to dst one at a time, aborting on misaligned addresses or a stalled responder.
module mem_dma_initiator #(
  parameter int          LEN_WIDTH = 10,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] PC_TAG    = 32'h0000_0C00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [31:0]          reg_pc,
  output logic                 mem_valid,
  output logic                 mem_instr,
  input  logic                 mem_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata
);

  localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [1:0]        ERR_NONE  = 2'd0;
  localparam logic [1:0]        ERR_ALIGN = 2'd1;
  localparam logic [1:0]        ERR_TMO   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FIN, S_ABORT} state_t;

  state_t                state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  hs;
  logic                  tmo;

  assign hs  = mem_valid_q & mem_ready;
  // Abort on the last stalled cycle so mem_valid is high for exactly TIMEOUT cycles.
  assign tmo = mem_valid_q & ~mem_ready & (wait_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          rem_d      = len;
          wait_d     = '0;
          err_code_d = ERR_NONE;
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            state_d    = S_ABORT;
            err_code_d = ERR_ALIGN;
          end else if (len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d     = S_RD;
            mem_valid_d = 1'b1;
            mem_addr_d  = src_addr;
            mem_wstrb_d = 4'h0;
          end
        end
      end
      S_RD: begin
        if (hs) begin
          // The write data register doubles as the read capture register.
          mem_valid_d = 1'b0;
          mem_wdata_d = mem_rdata;
          src_d       = src_q + 32'd4;
          state_d     = S_WR;
        end else if (tmo) begin
          mem_valid_d = 1'b0;
          err_code_d  = ERR_TMO;
          state_d     = S_ABORT;
        end else if (mem_valid_q) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = src_q;
          mem_wstrb_d = 4'h0;
          wait_d      = '0;
        end
      end
      S_WR: begin
        if (hs) begin
          mem_valid_d = 1'b0;
          dst_d       = dst_q + 32'd4;
          rem_d       = rem_q - LEN_WIDTH'(1);
          state_d     = (rem_q == LEN_WIDTH'(1)) ? S_FIN : S_RD;
        end else if (tmo) begin
          mem_valid_d = 1'b0;
          err_code_d  = ERR_TMO;
          state_d     = S_ABORT;
        end else if (mem_valid_q) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = dst_q;
          mem_wstrb_d = 4'hF;
          wait_d      = '0;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      wait_q      <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      wait_q      <= wait_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = (state_q == S_ABORT);
  assign err_code  = err_code_q;
  assign reg_pc    = PC_TAG;
  assign mem_instr = 1'b0;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Bench for mem_dma_initiator: vector table plus random copies, checked against a word-level
// copy model and an abstract memory responder.
module tb_mem_dma_initiator;
  localparam int          LW  = 10;
  localparam int          TMO = 8;
  localparam logic [31:0] PCT = 32'h0000_0C00;
  localparam int          LIM = 400;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [31:0]   src_addr, dst_addr;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [31:0]   reg_pc;
  logic          mem_valid, mem_instr, mem_ready;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  always #5 clk = ~clk;

  mem_dma_initiator #(.LEN_WIDTH(LW), .TIMEOUT(TMO), .PC_TAG(PCT)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .err_code(err_code), .reg_pc(reg_pc),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          wt;       // fixed wait cycles per access, -1 = random waits
    bit          never;    // responder never answers
    bit          repulse;  // extra start pulse mid-copy
    int          exp_code;
    int          exp_nhs;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } hs_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  hs_t hs_log[$];
  hs_t exp_hs[$];
  int done_cnt = 0, err_cnt = 0, vcyc = 0, proto_err = 0;
  int cfg_wait = 0;
  bit cfg_rand = 1'b0, cfg_never = 1'b0, cfg_stray = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Responder: answers after cur_wait stalled cycles; may toggle ready while idle.
  initial begin : responder
    int wcnt;
    int cur_wait;
    wcnt = 0;
    cur_wait = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_valid) begin
        wcnt = 0;
        cur_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
        mem_ready = cfg_stray ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end else if (!cfg_never && wcnt >= cur_wait) begin
        mem_ready = 1'b1;
        mem_rdata = rd_mem(mem_addr);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end
  end

  // Bus monitor: logs handshakes, applies writes, counts pulses and protocol violations.
  initial begin : monitor
    logic p_valid, p_hs, hs;
    logic [31:0] p_addr, p_wdata;
    logic [3:0] p_wstrb;
    p_valid = 1'b0; p_hs = 1'b0; p_addr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        p_valid = 1'b0;
        p_hs = 1'b0;
      end else begin
        hs = mem_valid && mem_ready;
        if (mem_valid) vcyc++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) proto_err++;
        if (p_hs && mem_valid) proto_err++;
        if (p_valid && !p_hs && mem_valid &&
            ({mem_addr, mem_wdata, mem_wstrb} != {p_addr, p_wdata, p_wstrb})) proto_err++;
        if (mem_valid && mem_addr[1:0] != 2'b00) proto_err++;
        if (hs) begin
          hs_log.push_back('{mem_addr, mem_wstrb, mem_wdata});
          if (mem_wstrb == 4'hF) mem[mem_addr] = mem_wdata;
        end
        p_valid = mem_valid; p_hs = hs;
        p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic run_vec(input int idx, input vec_t v);
    int lat, bad, exp_lat, exp_vc;
    bit fixed;
    logic [31:0] a, d;
    string p;
    p = $sformatf("v%0d", idx);
    fixed = (v.wt >= 0);
    cfg_rand = !fixed; cfg_wait = fixed ? v.wt : 0; cfg_never = v.never; cfg_stray = !fixed;
    for (int i = 0; i <= v.len; i++) begin
      a = v.src + 32'(4 * i); mem[a & ~32'h3] = $urandom;
      a = v.dst + 32'(4 * i); mem[a & ~32'h3] = $urandom;
    end
    // Reference: ascending word copy, performed only for a clean start.
    ref_mem = mem;
    exp_hs.delete();
    if (v.exp_code == 0 && !v.never) begin
      for (int i = 0; i < v.len; i++) begin
        a = v.src + 32'(4 * i);
        d = ref_mem[a];
        exp_hs.push_back('{a, 4'h0, 32'h0});
        a = v.dst + 32'(4 * i);
        ref_mem[a] = d;
        exp_hs.push_back('{a, 4'hF, d});
      end
    end
    hs_log.delete(); done_cnt = 0; err_cnt = 0; vcyc = 0;
    src_addr = v.src; dst_addr = v.dst; len = LW'(v.len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({p, "_busy1"}, busy, 1);
    chk({p, "_code_start"}, err_code, (v.exp_code == 1) ? 1 : 0);
    lat = 0;
    while (!(done || err) && lat < LIM) begin
      @(posedge clk); #1;
      lat++;
      start = (v.repulse && lat == 3);
      if (start) begin src_addr = 32'h40; dst_addr = 32'h80; len = LW'(7); end
    end
    start = 1'b0;
    chk({p, "_bound"}, (lat < LIM), 1);
    chk({p, "_done_err"}, {done, err}, (v.exp_code == 0) ? 2'b10 : 2'b01);
    chk({p, "_code"}, err_code, v.exp_code);
    if (fixed) begin
      exp_lat = (v.exp_code == 2) ? TMO : (v.exp_code == 1 || v.len == 0) ? 0 : 2 * v.len * (v.wt + 2) - 1;
      exp_vc  = (v.exp_code == 2) ? TMO : (v.exp_code == 1) ? 0 : 2 * v.len * (v.wt + 1);
      chk({p, "_latency"}, lat, exp_lat);
      chk({p, "_valid_cycles"}, vcyc, exp_vc);
    end
    @(posedge clk); #1;
    chk({p, "_busy0"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({p, "_done_cnt"}, done_cnt, (v.exp_code == 0) ? 1 : 0);
    chk({p, "_err_cnt"}, err_cnt, (v.exp_code != 0) ? 1 : 0);
    chk({p, "_code_sticky"}, err_code, v.exp_code);
    chk({p, "_nhs"}, hs_log.size(), v.exp_nhs);
    bad = 0;
    for (int i = 0; i < hs_log.size() && i < exp_hs.size(); i++) begin
      if (hs_log[i].addr != exp_hs[i].addr || hs_log[i].wstrb != exp_hs[i].wstrb) bad++;
      else if (exp_hs[i].wstrb == 4'hF && hs_log[i].wdata != exp_hs[i].wdata) bad++;
    end
    chk({p, "_hs_seq"}, bad, 0);
    bad = (mem.size() != ref_mem.size()) ? 1 : 0;
    foreach (ref_mem[k]) if (!mem.exists(k) || mem[k] !== ref_mem[k]) bad++;
    chk({p, "_mem"}, bad, 0);
  endtask

  initial begin : main
    vec_t tbl[11];
    vec_t v;
    int lat;
    bit mis;
    tbl[0]  = '{32'h0000_0100, 32'h0000_0200, 4, 1, 1'b0, 1'b0, 0, 8};
    tbl[1]  = '{32'h0000_0100, 32'h0000_0200, 0, 0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{32'h0000_0102, 32'h0000_0200, 4, 0, 1'b0, 1'b0, 1, 0};
    tbl[3]  = '{32'h0000_0100, 32'h0000_0203, 2, 0, 1'b0, 1'b0, 1, 0};
    tbl[4]  = '{32'h0000_0100, 32'h0000_0200, 2, 0, 1'b1, 1'b0, 2, 0};
    tbl[5]  = '{32'h0000_0400, 32'h0000_0500, 3, 0, 1'b0, 1'b1, 0, 6};
    tbl[6]  = '{32'h0000_0300, 32'h0000_0304, 4, 0, 1'b0, 1'b0, 0, 8};
    tbl[7]  = '{32'hFFFF_FFF8, 32'h0000_0600, 3, 2, 1'b0, 1'b0, 0, 6};
    tbl[8]  = '{32'h0000_0700, 32'hFFFF_FFFC, 2, 0, 1'b0, 1'b0, 0, 4};
    tbl[9]  = '{32'h0000_0800, 32'h0000_0800, 1, 3, 1'b0, 1'b0, 0, 2};
    tbl[10] = '{32'h0000_0908, 32'h0000_0900, 3, 1, 1'b0, 1'b0, 0, 6};

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("reg_pc", reg_pc, PCT);
    chk("mem_instr", mem_instr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

    // Reset while the second word's write is outstanding.
    cfg_rand = 1'b0; cfg_wait = 2; cfg_never = 1'b0; cfg_stray = 1'b0;
    hs_log.delete(); done_cnt = 0; err_cnt = 0;
    src_addr = 32'h0000_0A00; dst_addr = 32'h0000_0B00; len = LW'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!(hs_log.size() == 3 && mem_valid && mem_wstrb == 4'hF) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rstmid_reach", (lat < 100), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_valid", mem_valid, 0);
    chk("rstmid_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_nhs", hs_log.size(), 3);
    chk("rstmid_pulses", done_cnt + err_cnt, 0);
    chk("rstmid_idle", mem_valid, 0);
    run_vec(11, '{32'h0000_0A00, 32'h0000_0B00, 3, 1, 1'b0, 1'b0, 0, 6});

    // Random copies with random responder waits and stray ready pulses.
    for (int i = 0; i < 30; i++) begin
      v.src = 32'($urandom_range(0, 1023)) << 2;
      v.dst = 32'($urandom_range(0, 1023)) << 2;
      mis = ($urandom_range(0, 7) == 0);
      if (mis) begin
        if ($urandom_range(0, 1) == 1) v.src[1:0] = 2'($urandom_range(1, 3));
        else v.dst[1:0] = 2'($urandom_range(1, 3));
      end
      v.len = int'($urandom_range(0, 6));
      v.wt = -1; v.never = 1'b0; v.repulse = 1'b0;
      v.exp_code = mis ? 1 : 0;
      v.exp_nhs = mis ? 0 : 2 * v.len;
      run_vec(100 + i, v);
    end

    chk("protocol", proto_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
